key_debounce_sync: RTL and testbench

- Input-conditioning stage that sits directly upstream of the master-slave D flip-flop and latch datapath.
- Takes a raw, asynchronous, bouncing pushbutton or switch level, synchronizes it into the Clk domain, and debounces it with a counter-based FSM.
- Outputs a clean level (feeds the flip-flop D input), single-cycle rise/fall pulses, and a wrap-around press counter.

---
 rtl/key_debounce_sync_if.sv | 13 +
 rtl/key_debounce_sync.sv | 80 ++++++++
 tb/tb_key_debounce_sync.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_debounce_sync_if.sv
// key_debounce_sync_if: raw key input, count clear and debounced outputs
interface key_debounce_sync_if #(
    parameter int COUNT_W = 4
);
    logic               Din;
    logic               Clr;
    logic               Q;
    logic               Rise;
    logic               Fall;
    logic [COUNT_W-1:0] Count;
    modport master (output Din, Clr, input Q, Rise, Fall, Count);
    modport slave  (input Din, Clr, output Q, Rise, Fall, Count);
endinterface

// File: rtl/key_debounce_sync.sv
// key_debounce_sync: two-flop synchronizer, counter debounce FSM, edge pulses and press counter
module key_debounce_sync #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8,
    parameter int COUNT_W         = 4
) (
    input logic                Clk,
    input logic                Resetn,
    key_debounce_sync_if.slave bus
);
    typedef enum logic [1:0] {LOW, TO_HIGH, HIGH, TO_LOW} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic               r_s1, r_s2;
    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_q, r_rise, r_fall;
    logic [COUNT_W-1:0] r_count;
    logic               w_rise_now;
    assign w_rise_now = (r_state == TO_HIGH) && r_s2 && (r_cnt == LAST);
    assign bus.Q      = r_q;
    assign bus.Rise   = r_rise;
    assign bus.Fall   = r_fall;
    assign bus.Count  = r_count;
    // bring the asynchronous key level into the Clk domain
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= bus.Din;
            r_s2 <= r_s1;
        end
    end
    // debounce FSM with registered level, edge pulses and press counter
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= LOW;
            r_cnt   <= '0;
            r_q     <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_count <= '0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                LOW: if (r_s2) begin
                    r_state <= TO_HIGH;
                    r_cnt   <= '0;
                end
                TO_HIGH: if (!r_s2) begin
                    r_state <= LOW;
                    r_cnt   <= '0;
                end else if (r_cnt == LAST) begin
                    r_state <= HIGH;
                    r_q     <= 1'b1;
                    r_rise  <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                HIGH: if (!r_s2) begin
                    r_state <= TO_LOW;
                    r_cnt   <= '0;
                end
                TO_LOW: if (r_s2) begin
                    r_state <= HIGH;
                    r_cnt   <= '0;
                end else if (r_cnt == LAST) begin
                    r_state <= LOW;
                    r_q     <= 1'b0;
                    r_fall  <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                default: r_state <= LOW;
            endcase
            r_count <= bus.Clr ? '0 : w_rise_now ? r_count + 1'b1 : r_count;
        end
    end
endmodule

// File: tb/tb_key_debounce_sync.sv
// tb_key_debounce_sync: window-based reference model against DEBOUNCE_CYCLES=4 and =1 instances
module tb_key_debounce_sync;
    logic Clk = 1'b0;
    logic Resetn = 1'b0;
    logic din = 1'b0;
    logic clr = 1'b0;
    int   tests = 0;
    int   fails = 0;
    key_debounce_sync_if #(.COUNT_W(4)) b4 ();
    key_debounce_sync_if #(.COUNT_W(4)) b1 ();
    assign b4.Din = din;
    assign b4.Clr = clr;
    assign b1.Din = din;
    assign b1.Clr = clr;
    key_debounce_sync #(.DEBOUNCE_CYCLES(4), .CNT_W(8), .COUNT_W(4)) dut4 (.Clk(Clk), .Resetn(Resetn), .bus(b4));
    key_debounce_sync #(.DEBOUNCE_CYCLES(1), .CNT_W(8), .COUNT_W(4)) dut1 (.Clk(Clk), .Resetn(Resetn), .bus(b1));
    logic [6:0] got [2];
    assign got[0] = {b4.Q, b4.Rise, b4.Fall, b4.Count};
    assign got[1] = {b1.Q, b1.Rise, b1.Fall, b1.Count};
    always #5 Clk = ~Clk;
    // model: Din history per edge; the level flips when the Din samples taken
    // 2..D+2 edges ago (what the synchronizer delivers) all equal the opposite level
    bit         h [2][16];
    bit         mq [2];
    bit         mr [2];
    bit         mf [2];
    logic [3:0] mc [2];
    int         dc [2] = '{4, 1};

    function automatic logic [6:0] exp_of(input int n);
        return {mq[n], mr[n], mf[n], mc[n]};
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            for (int j = 0; j < 16; j++) h[n][j] = 1'b0;
            mq[n] = 1'b0;
            mr[n] = 1'b0;
            mf[n] = 1'b0;
            mc[n] = 4'd0;
        end
    endtask

    task automatic tick();
        bit all;
        @(posedge Clk);
        for (int n = 0; n < 2; n++) begin
            for (int j = 15; j > 0; j--) h[n][j] = h[n][j-1];
            h[n][0] = din;
            all = 1'b1;
            for (int j = 2; j <= dc[n] + 2; j++) if (h[n][j] == mq[n]) all = 1'b0;
            mr[n] = all && !mq[n];
            mf[n] = all && mq[n];
            if (all) mq[n] = !mq[n];
            mc[n] = clr ? 4'd0 : mr[n] ? mc[n] + 4'd1 : mc[n];
        end
        @(negedge Clk);
    endtask

    task automatic apply_reset();
        Resetn = 1'b0;
        model_reset();
        din = 1'b0;
        clr = 1'b0;
        repeat (2) @(negedge Clk);
        Resetn = 1'b1;
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        model_reset();
        din = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 2; n++) begin
                tests++;
                if (got[n] !== 7'd0) begin
                    fails++;
                    $display("FAIL reset inst%0d cyc%0d: got %b want 0000000", n, k, got[n]);
                end
            end
            @(negedge Clk);
        end
    endtask

    task automatic test_clean_press();
        apply_reset();
        din = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            tests++;
            if (b4.Rise !== (i == 7) || b4.Q !== (i >= 7)) begin
                fails++;
                $display("FAIL press_timing edge%0d: got rise=%b q=%b want rise=%b q=%b", i, b4.Rise, b4.Q, i == 7, i >= 7);
            end
            for (int n = 0; n < 2; n++) begin
                tests++;
                if (got[n] !== exp_of(n)) begin
                    fails++;
                    $display("FAIL press_model inst%0d edge%0d: got %b want %b", n, i, got[n], exp_of(n));
                end
            end
        end
        din = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            tests++;
            if (b4.Fall !== (i == 7) || b4.Q !== (i < 7) || b4.Rise !== 1'b0) begin
                fails++;
                $display("FAIL release_timing edge%0d: got fall=%b q=%b want fall=%b q=%b", i, b4.Fall, b4.Q, i == 7, i < 7);
            end
        end
        tests++;
        if (b4.Count !== 4'd1) begin
            fails++;
            $display("FAIL press_count: got %0d want 1", b4.Count);
        end
    endtask

    task automatic test_glitch();
        int rises;
        for (int len = 4; len <= 5; len++) begin
            apply_reset();
            rises = 0;
            din = 1'b1;
            for (int i = 1; i <= 20; i++) begin
                if (i == len + 1) din = 1'b0;
                tick();
                rises += int'(b4.Rise);
                for (int n = 0; n < 2; n++) begin
                    tests++;
                    if (got[n] !== exp_of(n)) begin
                        fails++;
                        $display("FAIL glitch%0d_model inst%0d edge%0d: got %b want %b", len, n, i, got[n], exp_of(n));
                    end
                end
            end
            tests++;
            if (rises != len - 4 || b4.Count !== 4'(len - 4)) begin
                fails++;
                $display("FAIL glitch%0d: got rises=%0d count=%0d want %0d", len, rises, b4.Count, len - 4);
            end
        end
    endtask

    task automatic test_bounce();
        bit pat [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        int rises = 0;
        int at = 0;
        apply_reset();
        for (int i = 1; i <= 20; i++) begin
            din = (i <= 5) ? pat[i-1] : 1'b1;
            tick();
            if (b4.Rise === 1'b1) begin
                rises++;
                at = i;
            end
            tests++;
            if (got[0] !== exp_of(0)) begin
                fails++;
                $display("FAIL bounce_model edge%0d: got %b want %b", i, got[0], exp_of(0));
            end
        end
        tests++;
        if (rises != 1 || at != 11 || b4.Count !== 4'd1) begin
            fails++;
            $display("FAIL bounce: got rises=%0d at=%0d count=%0d want 1 at 11 count 1", rises, at, b4.Count);
        end
    endtask

    task automatic test_wrap_clear();
        apply_reset();
        for (int p = 0; p < 19; p++) begin
            din = 1'b1;
            repeat (10) tick();
            din = 1'b0;
            repeat (10) tick();
            if (p == 15 || p == 18) begin
                tests++;
                if (b4.Count !== ((p == 15) ? 4'd0 : 4'd3) || got[1] !== exp_of(1)) begin
                    fails++;
                    $display("FAIL wrap_after%0d: got count=%0d inst1=%b want %0d inst1=%b", p + 1, b4.Count, got[1], (p == 15) ? 0 : 3, exp_of(1));
                end
            end
        end
        din = 1'b1;
        repeat (6) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tests++;
        if (b4.Rise !== 1'b1 || b4.Count !== 4'd0 || got[1] !== exp_of(1)) begin
            fails++;
            $display("FAIL clear_vs_rise: got rise=%b count=%0d inst1=%b want rise=1 count=0 inst1=%b", b4.Rise, b4.Count, got[1], exp_of(1));
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        din = 1'b1;
        repeat (10) tick();
        din = 1'b0;
        repeat (10) tick();
        din = 1'b1;
        repeat (4) tick();
        #1 Resetn = 1'b0;
        model_reset();
        #1;
        tests++;
        if (b4.Q !== 1'b0 || b4.Count !== 4'd0 || b1.Q !== 1'b0 || b1.Count !== 4'd0) begin
            fails++;
            $display("FAIL async_reset: got q=%b count=%0d q1=%b count1=%0d want 0", b4.Q, b4.Count, b1.Q, b1.Count);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            tests++;
            if (got[0] !== 7'd0) begin
                fails++;
                $display("FAIL async_hold cyc%0d: got %b want 0000000", k, got[0]);
            end
        end
        Resetn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            tests++;
            if (b4.Rise !== (i == 7) || got[0] !== exp_of(0)) begin
                fails++;
                $display("FAIL async_release edge%0d: got %b want %b rise_at=7", i, got[0], exp_of(0));
            end
        end
    endtask

    task automatic test_d1();
        int rises;
        apply_reset();
        din = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            tests++;
            if (b1.Rise !== (i == 4) || b1.Q !== (i >= 4)) begin
                fails++;
                $display("FAIL d1_hold edge%0d: got rise=%b q=%b want rise=%b q=%b", i, b1.Rise, b1.Q, i == 4, i >= 4);
            end
        end
        din = 1'b0;
        repeat (8) tick();
        for (int len = 1; len <= 2; len++) begin
            rises = 0;
            din = 1'b1;
            repeat (len) begin
                tick();
                rises += int'(b1.Rise);
            end
            din = 1'b0;
            for (int i = 0; i < 8; i++) begin
                tick();
                rises += int'(b1.Rise);
                tests++;
                if (got[1] !== exp_of(1)) begin
                    fails++;
                    $display("FAIL d1_pulse%0d_model edge%0d: got %b want %b", len, i, got[1], exp_of(1));
                end
            end
            tests++;
            if (rises != len - 1) begin
                fails++;
                $display("FAIL d1_pulse%0d: got rises=%0d want %0d", len, rises, len - 1);
            end
        end
    endtask

    task automatic test_random();
        int run = 0;
        apply_reset();
        for (int i = 0; i < 800; i++) begin
            if (run == 0) begin
                din = ~din;
                run = $urandom_range(1, 8);
            end
            run--;
            clr = ($urandom_range(0, 15) == 0);
            tick();
            for (int n = 0; n < 2; n++) begin
                tests++;
                if (got[n] !== exp_of(n)) begin
                    fails++;
                    $display("FAIL random inst%0d step%0d: got %b want %b", n, i, got[n], exp_of(n));
                end
            end
        end
        clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_wrap_clear();
        test_async_reset();
        test_d1();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
